// File: rtl/tally_rate_window_pkg.sv
// Shared widths, state encoding and limits for the tally rate window block.
package tally_rate_pkg;

  localparam int TALLY_W = 32;
  localparam int DROP_W  = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } trw_state_t;

endpackage

// File: rtl/tally_rate_window_if.sv
// Single-entry result channel carrying one window's increment and its index.
// A result transfers on a clock edge where valid_out && ready_in. The master holds
// delta_out and window_idx_out stable while valid_out=1 and ready_in=0.
interface tally_rate_window_if #(
  parameter int IDX_W = 16
);
  import tally_rate_pkg::*;

  logic               valid_out;
  logic               ready_in;
  logic [TALLY_W-1:0] delta_out;
  logic [IDX_W-1:0]   window_idx_out;

  modport master (
    output valid_out,
    output delta_out,
    output window_idx_out,
    input  ready_in
  );

  modport slave (
    input  valid_out,
    input  delta_out,
    input  window_idx_out,
    output ready_in
  );

endinterface

// File: rtl/tally_rate_window_timer.sv
// Window length counter: tc pulses on the edge where the count reaches
// WINDOW_CYCLES-1, then the count restarts from zero.
module window_timer #(
  parameter int unsigned WINDOW_CYCLES = 100_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run,
  input  logic restart,
  output logic tc
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

  logic [CW-1:0] count;

  assign tc = run && (count == LAST);

  // Dropping run discards the partial window so the next one starts clean.
  always_ff @(posedge clk_in) begin
    if (rst_in || restart || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tally_rate_window.sv
// Turns a free-running 32-bit tally into per-window increments, presented on a
// single-entry valid/ready slot, with a saturating count of dropped windows.
module tally_rate_window
  import tally_rate_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 100_000_000,
  parameter int          IDX_W         = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [TALLY_W-1:0] tally_in,
  input  logic               enable_in,
  tally_rate_window_if.master out_if,
  output logic [DROP_W-1:0]  drop_count_out,
  output trw_state_t         state_dbg
);

  trw_state_t         state;
  trw_state_t         state_nx;
  logic [TALLY_W-1:0] baseline;
  logic [IDX_W-1:0]   win_idx;
  logic               valid_r;
  logic [TALLY_W-1:0] delta_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DROP_W-1:0]  drop_cnt;

  logic               boundary;
  logic               consume;
  logic               slot_free;
  logic [TALLY_W-1:0] result;

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .run     ((state == RUN) && enable_in),
    .restart (state == IDLE),
    .tc      (boundary)
  );

  // Unsigned subtraction absorbs upstream wrap.
  assign result    = tally_in - baseline;
  assign consume   = valid_r && out_if.ready_in;
  assign slot_free = !valid_r || out_if.ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable_in)  state_nx = RUN;
      RUN:     if (!enable_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Baseline, window index, output slot and drop counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      baseline <= '0;
      win_idx  <= '0;
      valid_r  <= 1'b0;
      delta_r  <= '0;
      idx_r    <= '0;
      drop_cnt <= '0;
    end else begin
      if ((state == IDLE) && enable_in) begin
        baseline <= tally_in;
      end
      if (boundary) begin
        baseline <= tally_in;
        win_idx  <= win_idx + IDX_W'(1);
        if (slot_free) begin
          delta_r <= result;
          idx_r   <= win_idx;
          valid_r <= 1'b1;
        end else if (drop_cnt != DROP_MAX) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end else if (consume) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign out_if.valid_out      = valid_r;
  assign out_if.delta_out      = delta_r;
  assign out_if.window_idx_out = idx_r;
  assign drop_count_out        = drop_cnt;
  assign state_dbg             = state;

endmodule

// File: doc/tally_rate_window.md
Name: tally_rate_window

Overview:
- Downstream consumer of the 32-bit running tally produced by the current counter.
- Converts the free-running tally into per-window increments: the increase in tally over a fixed window of WINDOW_CYCLES clocks.
- Presents each increment on a valid/ready output for display or UART logging.
- Counts windows dropped because of backpressure.

Parameters:
- WINDOW_CYCLES, 100_000_000, window length in clocks; legal range 2 to 2^32-1.
- IDX_W, 16, width of the window sequence index.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- tally_in  input  32  running tally from the upstream counter; wraps modulo 2^32
- enable_in  input  1  level-sensitive; measurement runs while high
- ready_in  input  1  consumer accepts delta_out on an edge where valid_out && ready_in
- valid_out  output  1  delta_out and window_idx_out hold a result
- delta_out  output  32  tally increase over one window, modulo 2^32
- window_idx_out  output  IDX_W  sequence number of the presented window
- drop_count_out  output  8  windows lost because the output slot was full; saturates at 255

Behaviour:
- Reset:
  - state=IDLE; win_cnt=0; baseline=0; internal window index=0.
  - valid_out=0, delta_out=0, window_idx_out=0, drop_count_out=0.
  - Reset mid-window or with a pending output discards everything; no partial result is emitted.
- States: IDLE, RUN.
- IDLE:
  - win_cnt held at 0.
  - On an edge with enable_in=1: baseline<=tally_in, win_cnt<=0, state<=RUN.
- RUN:
  - enable_in=1 and win_cnt<WINDOW_CYCLES-1: win_cnt<=win_cnt+1.
  - enable_in=1 and win_cnt==WINDOW_CYCLES-1 (the boundary edge):
    - result = tally_in - baseline, truncated to 32 bits, so wrap is handled.
    - baseline<=tally_in; win_cnt<=0; internal window index increments and wraps at 2^IDX_W.
  - A boundary therefore occurs exactly WINDOW_CYCLES edges after the baseline capture, and every WINDOW_CYCLES edges after that.
  - enable_in=0: state<=IDLE. The partial window is discarded and the index does not advance. A pending output is retained and can still be consumed.
- Output slot (single entry):
  - Slot is free if valid_out=0, or if valid_out && ready_in on the same edge (simultaneous consume-and-load is allowed).
  - On a boundary edge with a free slot: delta_out<=result, window_idx_out<=pre-increment index, valid_out<=1.
  - Result is visible on the cycle after the boundary edge (latency 1).
  - On a boundary edge with the slot full and no consume: the result is dropped, drop_count_out increments (saturating at 255), and the held output is unchanged.
  - No boundary and valid_out && ready_in: valid_out<=0. delta_out and window_idx_out keep their last value.
  - While valid_out=1 and ready_in=0, delta_out and window_idx_out are stable.
- Arithmetic: all tally math is unsigned modulo 2^32; there is no overflow flag. win_cnt is $clog2(WINDOW_CYCLES) bits wide.
- enable_in toggling on the boundary edge itself: if enable_in=0, the boundary is not taken.

Decomposition:
- Package tally_rate_pkg:
  - TALLY_W=32, DROP_W=8.
  - typedef enum logic {IDLE, RUN} trw_state_t.
  - DROP_MAX constant.
- Sub-module window_timer:
  - Parameterised terminal-count generator.
  - Inputs: clk_in, rst_in, run, restart. Output: tc pulse on the edge where count==WINDOW_CYCLES-1.
- The top level holds the FSM, baseline, output slot and drop counter.

Test Plan (WINDOW_CYCLES=10, IDX_W=16):
- Steady rate: tally increments every clock from 0; enable high; ready_in=1.
  - Expect valid_out pulses every 10 cycles, each delta_out=10.
  - window_idx_out=0,1,2,…; drop_count_out=0.
- Wrap: tally starts at 0xFFFF_FFFA and increments every clock.
  - First delta_out=10 (computed across the wrap); baseline afterwards = 0x0000_0004.
- Backpressure: ready_in=0 for 35 cycles, tally +1/clock.
  - First result (delta 10, idx 0) is held stable throughout.
  - Next two boundaries drop; drop_count_out=2.
  - After ready_in rises, the next result presented is idx 3.
- Simultaneous consume and load: assert ready_in only on boundary edges.
  - valid_out stays high continuously; each window is delivered; no drops.
- Enable drop: enable_in deasserted at win_cnt=5, then reasserted 20 cycles later, tally +2/clock.
  - No output for the partial window.
  - Next delta_out=20, window_idx_out continues from its prior value.
- Reset mid-operation: rst_in pulsed with valid_out=1 and drop_count_out=3.
  - The next cycle shows all outputs 0 and state IDLE.
  - First post-reset delta is measured from a fresh baseline.
